// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_DONE
  } arb_state_e;

  localparam int unsigned UART_DATA_WIDTH = 8;

  // Handshake strobe widths between the arbiter and uart_tx.
  localparam int unsigned UART_START_W = 1;
  localparam int unsigned UART_DONE_W  = 1;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] sum;

  // Scan N positions starting at ptr; the wrap is done against N so non-power-of-two N works.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(N)) begin
        sum = sum - SW'(N);
      end
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        idx   = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers,
// with optional locked bursts of up to MAX_BURST bytes per grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = UART_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [N_REQ-1:0]            i_req,
  input  logic [N_REQ-1:0]            i_lock,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_data,
  output logic [N_REQ-1:0]            o_ack,
  output logic [UART_START_W-1:0]     o_tx_start,
  output logic [DATA_WIDTH-1:0]       o_tx_data,
  input  logic [UART_DONE_W-1:0]      i_tx_done,
  output logic [$clog2(N_REQ)-1:0]    o_grant_id,
  output logic                        o_busy
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;

  arb_state_e               state_q, state_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [IW-1:0]            g_q, g_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [BW-1:0]            cnt_q, cnt_d;
  logic [N_REQ-1:0]         ack_q, ack_d;
  logic [UART_START_W-1:0]  start_q, start_d;
  logic                     busy_q, busy_d;

  logic                     pick_found;
  logic [IW-1:0]            pick_idx;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req   (i_req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and registered-output computation; strobes are set one cycle early so they
  // appear from the flops in the START cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    start_d = '0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          g_d     = pick_idx;
          data_d  = i_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          ack_d   = N_REQ'(1) << pick_idx;
          start_d = '1;
          busy_d  = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (i_tx_done[0]) begin
          if (i_lock[g_q] && i_req[g_q] && (cnt_q < BW'(MAX_BURST - 1))) begin
            data_d  = i_data[g_q*DATA_WIDTH +: DATA_WIDTH];
            ack_d   = N_REQ'(1) << g_q;
            start_d = '1;
            cnt_d   = cnt_q + BW'(1);
            state_d = ST_START;
          end else begin
            ptr_d   = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + IW'(1);
            cnt_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without issuing an ack.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      start_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_tx_start = start_q;
  assign o_tx_data  = data_q;
  assign o_grant_id = g_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-requester/16-burst instance and a
// 3-requester/no-burst instance.
module tb_uart_tx_arbiter;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;

  logic [3:0]  req  = '0;
  logic [3:0]  lock = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic [0:0]  start;
  logic [0:0]  done = '0;
  logic [7:0]  txd;
  logic [1:0]  gid;
  logic        busy;

  logic [2:0]  req3  = '0;
  logic [2:0]  lock3 = '0;
  logic [23:0] data3 = 24'h33_22_11;
  logic [2:0]  ack3;
  logic [0:0]  start3;
  logic [0:0]  done3 = '0;
  logic [7:0]  txd3;
  logic [1:0]  gid3;
  logic        busy3;

  int checks   = 0;
  int failures = 0;
  int acks     = 0;
  int a0       = 0;

  always #5 clk = ~clk;

  // Count cycles carrying an ack on the 4-requester instance.
  always @(negedge clk) if (|ack) acks++;

  uart_tx_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(16)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req      (req),
    .i_lock     (lock),
    .i_data     (data),
    .o_ack      (ack),
    .o_tx_start (start),
    .o_tx_data  (txd),
    .i_tx_done  (done),
    .o_grant_id (gid),
    .o_busy     (busy)
  );

  uart_tx_arbiter #(.N_REQ(3), .DATA_WIDTH(8), .MAX_BURST(1)) dut3 (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req      (req3),
    .i_lock     (lock3),
    .i_data     (data3),
    .o_ack      (ack3),
    .o_tx_start (start3),
    .o_tx_data  (txd3),
    .i_tx_done  (done3),
    .o_grant_id (gid3),
    .o_busy     (busy3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One unlocked byte: arbitration edge, START, WAIT_DONE, done pulse, release.
  task automatic do_byte(input string tag, input int unsigned g, input logic [7:0] d,
                         input logic [3:0] clr);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    tick;
    check({tag, "_start"}, 32'(start), 32'd1);
    check({tag, "_ack"},   32'(ack),   32'(oh));
    check({tag, "_gid"},   32'(gid),   g);
    check({tag, "_data"},  32'(txd),   32'(d));
    check({tag, "_busy"},  32'(busy),  32'd1);
    req = req & ~clr;
    tick;
    check({tag, "_wstart"}, 32'(start), 32'd0);
    check({tag, "_wack"},   32'(ack),   32'd0);
    check({tag, "_wbusy"},  32'(busy),  32'd1);
    check({tag, "_wdata"},  32'(txd),   32'(d));
    done = 1'b1;
    tick;
    done = 1'b0;
    check({tag, "_rbusy"},  32'(busy),  32'd0);
    check({tag, "_rstart"}, 32'(start), 32'd0);
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick;
    check("rst_ack",   32'(ack),   32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_data",  32'(txd),   32'd0);
    check("rst_gid",   32'(gid),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    rst = 1'b0;
  endtask

  initial begin
    // Reset values on both instances.
    tick;
    apply_reset;
    check("rst3_busy",  32'(busy3),  32'd0);
    check("rst3_start", 32'(start3), 32'd0);
    check("rst3_gid",   32'(gid3),   32'd0);

    // 1: single requester 2 with 0x41, then all request: ptr=3 so requester 3 wins.
    data = {8'hA3, 8'h41, 8'hA1, 8'hA0};
    req  = 4'b0100;
    do_byte("t1", 2, 8'h41, 4'b0100);
    req = 4'b1111;
    do_byte("t1_ptr", 3, 8'hA3, 4'b0000);
    req = 4'b0000;
    apply_reset;

    // 2: all four held, no lock: strict rotation from requester 0.
    data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req  = 4'b1111;
    a0   = acks;
    for (int i = 0; i < 8; i++) begin
      do_byte("t2", i % 4, 8'(8'hA0 + (i % 4)), 4'b0000);
    end
    req = 4'b0000;
    check("t2_acks", 32'(acks - a0), 32'd8);

    // 3: locked burst from requester 1 (ptr=0 now) while requester 0 waits.
    req  = 4'b0010;
    lock = 4'b0010;
    data[15:8] = 8'h01;
    tick;
    check("t3_first_start", 32'(start), 32'd1);
    check("t3_first_gid",   32'(gid),   32'd1);
    check("t3_first_data",  32'(txd),   32'h01);
    req = 4'b0011;
    tick;
    for (int k = 2; k <= 16; k++) begin
      data[15:8] = 8'(k);
      done = 1'b1;
      tick;
      done = 1'b0;
      check("t3_cont_start", 32'(start), 32'd1);
      check("t3_cont_ack",   32'(ack),   32'b0010);
      check("t3_cont_data",  32'(txd),   k);
      tick;
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t3_rel_busy",  32'(busy),  32'd0);
    check("t3_rel_start", 32'(start), 32'd0);
    lock = 4'b0000;
    req  = 4'b0001;
    tick;
    check("t3_next_gid",   32'(gid),   32'd0);
    check("t3_next_ack",   32'(ack),   32'b0001);
    check("t3_next_start", 32'(start), 32'd1);
    req = 4'b0000;
    tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t3_next_rel", 32'(busy), 32'd0);

    // 5: done in IDLE and in START is ignored; one ack per byte.
    a0   = acks;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t5_idle_busy",  32'(busy),  32'd0);
    check("t5_idle_start", 32'(start), 32'd0);
    req = 4'b0001;
    tick;
    check("t5_start", 32'(start), 32'd1);
    check("t5_gid",   32'(gid),   32'd0);
    req  = 4'b0000;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t5_start_done_busy", 32'(busy), 32'd1);
    tick;
    check("t5_hold_busy", 32'(busy), 32'd1);
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t5_rel_busy", 32'(busy), 32'd0);
    check("t5_acks", 32'(acks - a0), 32'd1);

    // 4: N_REQ=3, MAX_BURST=1: lock ignored, wrap from ptr=2 to 0, then 1.
    req3  = 3'b010;
    lock3 = 3'b010;
    tick;
    check("t4_g1_gid", 32'(gid3), 32'd1);
    check("t4_g1_ack", 32'(ack3), 32'b010);
    check("t4_g1_data", 32'(txd3), 32'h22);
    tick;
    done3 = 1'b1;
    tick;
    done3 = 1'b0;
    check("t4_noburst_busy",  32'(busy3),  32'd0);
    check("t4_noburst_start", 32'(start3), 32'd0);
    req3  = 3'b011;
    lock3 = 3'b000;
    tick;
    check("t4_wrap_gid", 32'(gid3), 32'd0);
    check("t4_wrap_ack", 32'(ack3), 32'b001);
    tick;
    done3 = 1'b1;
    tick;
    done3 = 1'b0;
    check("t4_wrap_rel", 32'(busy3), 32'd0);
    req3 = 3'b111;
    tick;
    check("t4_next_gid", 32'(gid3), 32'd1);
    check("t4_next_ack", 32'(ack3), 32'b010);
    req3 = 3'b000;
    tick;
    done3 = 1'b1;
    tick;
    done3 = 1'b0;

    // 6: reset while waiting for done, then requester 3 gets a normal grant.
    req = 4'b0100;
    tick;
    check("t6_pre_gid", 32'(gid), 32'd2);
    req = 4'b0000;
    tick;
    a0 = acks;
    rst = 1'b1;
    #1;
    check("t6_async_busy", 32'(busy), 32'd0);
    tick;
    check("t6_rst_busy",  32'(busy),  32'd0);
    check("t6_rst_ack",   32'(ack),   32'd0);
    check("t6_rst_start", 32'(start), 32'd0);
    check("t6_rst_data",  32'(txd),   32'd0);
    check("t6_rst_gid",   32'(gid),   32'd0);
    rst = 1'b0;
    req = 4'b1000;
    tick;
    check("t6_post_start", 32'(start), 32'd1);
    check("t6_post_ack",   32'(ack),   32'b1000);
    check("t6_post_gid",   32'(gid),   32'd3);
    check("t6_post_data",  32'(txd),   32'hA3);
    req = 4'b0000;
    tick;
    done = 1'b1;
    tick;
    done = 1'b0;
    check("t6_post_rel", 32'(busy), 32'd0);
    check("t6_acks", 32'(acks - a0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
